// File: rtl/dcache_controller_pkg.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_pkg
// Shared types and encodings for the data cache controller.
//   cache_state_t : controller FSM states (IDLE, WRITEBACK, FILL)
//   CIN_MEM/CIN_RT     : cache_input_type selects (fill data / store data)
//   MADDR_ALU/MADDR_WB : memory_address_type selects (ALU address / victim)
// ---------------------------------------------------------------------------
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_t;

  localparam logic CIN_MEM   = 1'b0;
  localparam logic CIN_RT    = 1'b1;
  localparam logic MADDR_ALU = 1'b0;
  localparam logic MADDR_WB  = 1'b1;

endpackage

// File: rtl/dcache_controller_mem_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_wait_counter
// Times one fixed-latency main memory phase of MAX cycles.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, counter to 0
//   clr   : synchronous clear to 0 (has priority over en)
//   en    : count this cycle
//   done  : high in the last cycle of the phase (count == MAX-1 while en)
// The counter wraps to 0 on its own after done, so back-to-back phases
// (writeback followed by fill) need no extra clear.
// ---------------------------------------------------------------------------
module mem_wait_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] count;

  // Count cycles of the current memory phase, wrapping at the last cycle so
  // the value never exceeds MAX-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign done = en && (count == LAST);

endmodule

// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
// Memory-stage data cache control FSM. Resolves load/store requests as hits,
// or sequences an optional dirty-victim writeback followed by a line fill
// against fixed-latency main memory, stalling the pipeline meanwhile.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   mem_read, mem_write  : load / store request (store wins if both set)
//   cache_hit            : tag match and valid for the current address
//   cache_dirty          : victim line is dirty
//   we_cache             : cache write enable
//   cache_input_type     : 0 fill data from memory, 1 store data
//   set_dirty, set_valid : dirty/valid bits written with we_cache
//   memory_address_type  : 1 victim writeback address, 0 ALU address
//   mem_write_en         : main memory write strobe
//   mem_read_en          : main memory read strobe
//   stall                : freeze upstream pipeline registers
// Outputs are combinational from state, wait counter and (in IDLE) the
// request inputs, and are forced low while rst_n is asserted.
// ---------------------------------------------------------------------------
module dcache_controller
  import dcache_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read,
  input  logic mem_write,
  input  logic cache_hit,
  input  logic cache_dirty,
  output logic we_cache,
  output logic cache_input_type,
  output logic set_dirty,
  output logic set_valid,
  output logic memory_address_type,
  output logic mem_write_en,
  output logic mem_read_en,
  output logic stall
);

  cache_state_t state;
  logic         req;
  logic         is_store;
  logic         wait_clr;
  logic         wait_en;
  logic         wait_done;

  assign req      = mem_read | mem_write;
  assign is_store = mem_write;

  // The counter idles at 0 in IDLE and runs only during memory phases.
  assign wait_clr = (state == IDLE);
  assign wait_en  = (state == WRITEBACK) || (state == FILL);

  mem_wait_counter #(
    .MAX (MEM_LATENCY)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .done  (wait_done)
  );

  // State register. A miss leaves IDLE towards writeback when the victim is
  // dirty, otherwise straight to fill; once started, a sequence runs to
  // completion regardless of the request or hit/dirty inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req && !cache_hit) begin
            state <= cache_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (wait_done) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (wait_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode. The fill's cache write happens only in the last memory
  // cycle, so a reset mid-fill never writes a partial line. Gating with
  // rst_n keeps every strobe low for the whole reset, even with a request
  // pending in IDLE.
  always_comb begin
    we_cache            = 1'b0;
    cache_input_type    = CIN_MEM;
    set_dirty           = 1'b0;
    set_valid           = 1'b0;
    memory_address_type = MADDR_ALU;
    mem_write_en        = 1'b0;
    mem_read_en         = 1'b0;
    stall               = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (cache_hit) begin
              if (is_store) begin
                we_cache         = 1'b1;
                cache_input_type = CIN_RT;
                set_dirty        = 1'b1;
                set_valid        = 1'b1;
              end
            end else begin
              stall = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          stall               = 1'b1;
          memory_address_type = MADDR_WB;
          mem_write_en        = 1'b1;
        end
        FILL: begin
          stall               = 1'b1;
          memory_address_type = MADDR_ALU;
          mem_read_en         = 1'b1;
          if (wait_done) begin
            we_cache         = 1'b1;
            cache_input_type = CIN_MEM;
            set_valid        = 1'b1;
            set_dirty        = 1'b0;
          end
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule
